// File: rtl/struct_word_packer.sv
// Byte-pair to 16-bit word packer with pad-on-flush and an output FIFO.
// Words are emitted high byte first on a valid/ready interface.
module struct_word_packer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 i_byte,
    input  logic                       i_byte_valid,
    output logic                       o_byte_ready,
    input  logic                       i_flush,
    output logic [15:0]                o_packed_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [15:0]                o_word_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        S_HI = 1'b0,
        S_LO = 1'b1
    } state_t;

    state_t         state;
    logic           flush_pend;
    logic [7:0]     hi_reg;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic [15:0]    word_count;

    logic           full;
    logic           accept;
    state_t         state_after;
    logic [7:0]     hi_after;
    logic           pend_eff;
    logic           byte_push;
    logic           pad_push;
    logic           push;
    logic [15:0]    push_data;
    logic           pop;

    assign full         = (level == LW'(DEPTH));
    assign o_byte_ready = !flush_pend && ((state == S_HI) || !full);
    assign o_valid      = (level != '0);
    assign o_packed_data = mem[rd_ptr];
    assign o_level      = level;
    assign o_word_count = word_count;

    // Flush is judged against the state after this cycle's byte, so a
    // high byte arriving with i_flush is padded out in the same cycle.
    always_comb begin
        accept      = i_byte_valid && o_byte_ready;
        state_after = state;
        hi_after    = hi_reg;
        byte_push   = 1'b0;
        if (accept) begin
            if (state == S_HI) begin
                state_after = S_LO;
                hi_after    = i_byte;
            end else begin
                state_after = S_HI;
                byte_push   = 1'b1;
            end
        end
        pend_eff  = flush_pend || (i_flush && (state_after == S_LO));
        pad_push  = pend_eff && !full;
        push      = byte_push || pad_push;
        push_data = byte_push ? {hi_reg, i_byte} : {hi_after, 8'h00};
        pop       = o_valid && i_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_HI;
            flush_pend <= 1'b0;
            hi_reg     <= 8'h00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            word_count <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            hi_reg <= hi_after;
            if (pad_push) begin
                state      <= S_HI;
                flush_pend <= 1'b0;
            end else begin
                state      <= state_after;
                flush_pend <= pend_eff;
            end
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
                word_count  <= word_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_struct_word_packer.sv
// Directed self-checking bench for struct_word_packer.
// Each scenario task drives stimulus and compares against hand values.
module tb_struct_word_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        i_flush;
    logic [15:0] o_packed_data;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_level;
    logic [15:0] o_word_count;

    int checks;
    int failures;

    struct_word_packer #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_byte        (i_byte),
        .i_byte_valid  (i_byte_valid),
        .o_byte_ready  (o_byte_ready),
        .i_flush       (i_flush),
        .o_packed_data (o_packed_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_level       (o_level),
        .o_word_count  (o_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Present one byte and hold it until accepted, bounded.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        i_byte = b;
        i_byte_valid = 1'b1;
        while (!o_byte_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL send_timeout byte=%h ready=%b", b, o_byte_ready);
        end
        tick();
        i_byte_valid = 1'b0;
    endtask

    task automatic pop_one();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b exp=0", o_valid);
        end
        checks++;
        if (o_level !== 3'd0) begin
            failures++;
            $display("FAIL rst_level got=%0d exp=0", o_level);
        end
        checks++;
        if (o_packed_data !== 16'h0000) begin
            failures++;
            $display("FAIL rst_data got=%h exp=0000", o_packed_data);
        end
        checks++;
        if (o_word_count !== 16'h0000) begin
            failures++;
            $display("FAIL rst_count got=%h exp=0000", o_word_count);
        end
        checks++;
        if (o_byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready got=%b exp=1", o_byte_ready);
        end
    endtask

    task automatic test_basic();
        logic [8:0] sum;
        i_ready = 1'b1;
        i_byte_valid = 1'b1;
        i_byte = 8'h1A;
        tick();
        i_byte = 8'h2B;
        tick();
        i_byte_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_packed_data !== 16'h1A2B) begin
            failures++;
            $display("FAIL basic_word got=%b/%h exp=1/1a2b",
                     o_valid, o_packed_data);
        end
        sum = 9'(o_packed_data[15:12]) + 9'(o_packed_data[11:4])
            + 9'(o_packed_data[3:0]);
        checks++;
        if (sum !== 9'h0AE) begin
            failures++;
            $display("FAIL basic_sum got=%h exp=0ae", sum);
        end
        checks++;
        if (o_word_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=1", o_word_count);
        end
        tick();
        i_ready = 1'b0;
        checks++;
        if (o_level !== 3'd0) begin
            failures++;
            $display("FAIL basic_drain got=%0d exp=0", o_level);
        end
    endtask

    task automatic test_fill();
        logic [15:0] exp_w [5];
        exp_w[0] = 16'h0102;
        exp_w[1] = 16'h0304;
        exp_w[2] = 16'h0506;
        exp_w[3] = 16'h0708;
        exp_w[4] = 16'h090A;
        do_reset();
        i_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
        end
        checks++;
        if (o_level !== 3'd4 || o_byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_full got=%0d/%b exp=4/1",
                     o_level, o_byte_ready);
        end
        send_byte(8'h09);
        checks++;
        if (o_byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_stall got=%b exp=0", o_byte_ready);
        end
        i_byte = 8'h0A;
        i_byte_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        checks++;
        if (o_level !== 3'd3 || o_byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_pop got=%0d/%b exp=3/1",
                     o_level, o_byte_ready);
        end
        tick();
        i_byte_valid = 1'b0;
        checks++;
        if (o_level !== 3'd4 || o_word_count !== 16'd5) begin
            failures++;
            $display("FAIL fill_tenth got=%0d/%0d exp=4/5",
                     o_level, o_word_count);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (o_packed_data !== exp_w[i]) begin
                failures++;
                $display("FAIL fill_order%0d got=%h exp=%h",
                         i, o_packed_data, exp_w[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_flush_empty();
        do_reset();
        i_ready = 1'b0;
        send_byte(8'hC3);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_packed_data !== 16'hC300) begin
            failures++;
            $display("FAIL flush_word got=%b/%h exp=1/c300",
                     o_valid, o_packed_data);
        end
        checks++;
        if (o_word_count !== 16'd1 || o_byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_state got=%0d/%b exp=1/1",
                     o_word_count, o_byte_ready);
        end
        send_byte(8'hD4);
        send_byte(8'hE5);
        pop_one();
        checks++;
        if (o_packed_data !== 16'hD4E5) begin
            failures++;
            $display("FAIL flush_next got=%h exp=d4e5", o_packed_data);
        end
        pop_one();
    endtask

    task automatic test_flush_full();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h1213;
        exp_w[1] = 16'h1415;
        exp_w[2] = 16'h1617;
        exp_w[3] = 16'h7E00;
        do_reset();
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h10 + i));
        end
        send_byte(8'h7E);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checks++;
        if (o_level !== 3'd4 || o_byte_ready !== 1'b0
            || o_word_count !== 16'd4) begin
            failures++;
            $display("FAIL ffull_hold got=%0d/%b/%0d exp=4/0/4",
                     o_level, o_byte_ready, o_word_count);
        end
        pop_one();
        checks++;
        if (o_level !== 3'd3 || o_byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL ffull_pop got=%0d/%b exp=3/0",
                     o_level, o_byte_ready);
        end
        tick();
        checks++;
        if (o_level !== 3'd4 || o_byte_ready !== 1'b1
            || o_word_count !== 16'd5) begin
            failures++;
            $display("FAIL ffull_pad got=%0d/%b/%0d exp=4/1/5",
                     o_level, o_byte_ready, o_word_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_packed_data !== exp_w[i]) begin
                failures++;
                $display("FAIL ffull_order%0d got=%h exp=%h",
                         i, o_packed_data, exp_w[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_ready = 1'b0;
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h23);
        i_byte = 8'h24;
        i_byte_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_byte_valid = 1'b0;
        i_ready = 1'b0;
        checks++;
        if (o_level !== 3'd1 || o_packed_data !== 16'h2324) begin
            failures++;
            $display("FAIL b2b got=%0d/%h exp=1/2324",
                     o_level, o_packed_data);
        end
        pop_one();
    endtask

    task automatic test_midreset();
        do_reset();
        i_ready = 1'b0;
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h55);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_level !== 3'd0
            || o_byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL mrst_async got=%b/%0d/%b exp=0/0/1",
                     o_valid, o_level, o_byte_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h12);
        send_byte(8'h34);
        checks++;
        if (o_packed_data !== 16'h1234 || o_level !== 3'd1) begin
            failures++;
            $display("FAIL mrst_word got=%h/%0d exp=1234/1",
                     o_packed_data, o_level);
        end
        pop_one();
    endtask

    task automatic test_wrap();
        do_reset();
        i_ready = 1'b1;
        i_flush = 1'b1;
        i_byte_valid = 1'b1;
        i_byte = 8'h9C;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        checks++;
        if (o_word_count !== 16'hFFFF || o_packed_data !== 16'h9C00) begin
            failures++;
            $display("FAIL wrap_max got=%h/%h exp=ffff/9c00",
                     o_word_count, o_packed_data);
        end
        tick();
        i_flush = 1'b0;
        i_byte_valid = 1'b0;
        checks++;
        if (o_word_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero got=%h exp=0000", o_word_count);
        end
        tick();
        i_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        i_byte = 8'h00;
        i_byte_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_flush_empty();
        test_flush_full();
        test_back_to_back();
        test_midreset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/struct_word_packer.md
# struct_word_packer

Upstream feeder for the packed-struct member-sum stage. It takes a byte stream and assembles bytes in pairs into 16-bit packed words, high byte first. Completed words are buffered in a small FIFO and presented on a valid/ready interface. The downstream stage slices each word as part1 = [15:12], part2 = [11:4], part3 = [3:0]. The block also pads out a dangling half-word on flush and keeps a running count of words produced.

## Interface
- DEPTH, 4, output FIFO depth in words; power of two, ≥ 2
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- i_byte  input  8  incoming byte
- i_byte_valid  input  1  i_byte is valid this cycle
- o_byte_ready  output  1  block accepts i_byte this cycle
- i_flush  input  1  single-cycle request to pad and emit a pending high byte
- o_packed_data  output  16  FIFO head word
- o_valid  output  1  o_packed_data is valid
- i_ready  input  1  downstream consumes the head word this cycle
- o_level  output  $clog2(DEPTH)+1  number of words currently in the FIFO
- o_word_count  output  16  total words pushed since reset; wraps

## Operation
- State machine, 2 states:
  - S_HI: awaiting high byte. Reset state.
  - S_LO: high byte latched in hi_reg, awaiting low byte.
- Byte accept = i_byte_valid & o_byte_ready.
- o_byte_ready = (state==S_HI & !flush_pend) | (state==S_LO & o_level!=DEPTH & !flush_pend).
  - Combinational from registered state only; no path from i_ready or i_byte_valid.
- S_HI + accept: hi_reg ← i_byte, go to S_LO. No push.
- S_LO + accept: push {hi_reg, i_byte}, go to S_HI.
- Flush:
  - i_flush sets flush_pend if, after this cycle's byte accept, state is S_LO. Otherwise i_flush is ignored.
  - While flush_pend and FIFO not full: push {hi_reg, 8'h00}, clear flush_pend, go to S_HI.
  - If i_flush arrives in the same cycle a high byte is accepted, the pad push happens in that same cycle when space exists (one push total).
- FIFO:
  - Push and pop in the same cycle are allowed at any level except full, since push is impossible when full.
  - Net level is unchanged on simultaneous push and pop.
  - Pop = o_valid & i_ready. i_ready while empty is ignored.
- o_valid = (o_level != 0).
- o_packed_data = storage at read pointer. Storage is reset to 0. The value is stable while o_valid & !i_ready.
- o_word_count increments by 1 per push, including pad pushes; 16'hFFFF → 16'h0000.
- No arithmetic on data; bytes are concatenated unmodified.

## Timing
- Reset values: state S_HI, flush_pend 0, hi_reg 0, o_level 0, o_valid 0, o_packed_data 16'h0000, o_word_count 0, o_byte_ready 1.
- Reset mid-word discards hi_reg, any pending flush and all FIFO contents. o_byte_ready returns to 1 immediately.
- Latency:
  - Low byte accepted at edge N → word visible with o_valid=1 after edge N (cycle N+1) when the FIFO was empty.
  - Otherwise the word queues behind earlier words.
- Pad push occurs at the first edge where flush_pend=1 and level<DEPTH.
- Throughput: one word per two accepted bytes, back-to-back bytes allowed.
- Data is never dropped, duplicated or reordered.

## Test plan
- Reset, then bytes 0x1A, 0x2B on consecutive cycles, i_ready=1:
  - o_packed_data=0x1A2B with o_valid=1 one cycle after 0x2B is accepted.
  - Downstream member sum = 0xAE.
  - o_word_count=1.
- i_ready=0, DEPTH=4, stream 10 bytes:
  - 8 bytes fill the FIFO (o_level=4); the 9th (high) byte is accepted; o_byte_ready drops for the 10th.
  - After one i_ready=1 cycle, the 10th byte is accepted and the word is pushed.
  - Output order matches input.
- Byte 0xC3 then i_flush with an empty FIFO → word 0xC300 emitted; state returns to S_HI; o_word_count increments.
- FIFO full with high byte 0x7E pending, pulse i_flush:
  - No push; o_byte_ready=0.
  - One pop cycle, then 0x7E00 is pushed on the next edge; o_byte_ready returns to 1.
- o_level=1, simultaneous low-byte push and pop → o_level stays 1; head advances correctly.
- Mid-word reset: accept 0x55, assert rst asynchronously → o_valid=0, o_level=0 immediately; next bytes 0x12, 0x34 yield 0x1234, not 0x5512.
- Force 65535 pushes, then one more → o_word_count wraps to 0.
